rca8_registered: RTL and testbench
==================================

Name: rca8_registered

Overview:
- 8-bit ripple-carry adder with a registered output stage, used as the adder datapath of the 8-bit ALU.
- Computes A + B + Cin through a chain of eight 1-bit full-adder cells. Each carry ripples from bit i to bit i+1; no carry-lookahead.
- Sum, carry-out and status flags are captured in output registers one clock after the operands are presented.

Parameters:
- WIDTH, 8, operand and sum width. Only the value 8 is required to be supported and verified.

Ports:
- clk  input  1  system clock; all registers are updated on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  qualifies A, B and Cin in the current cycle.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- Cin  input  1  carry-in.
- Sum  output  8  registered sum bits [7:0].
- Cout  output  1  registered carry-out of bit 7.
- Overflow  output  1  registered two's-complement overflow: carry into bit 7 XOR carry out of bit 7.
- Zero  output  1  registered flag, set when Sum == 0.
- out_valid  output  1  set when Sum, Cout and the flags hold a new result.

Behaviour:
- Datapath structure:
  - Bit 0 takes Cin as its carry input.
  - Each full-adder cell produces s = a ^ b ^ c and co = (a & b) | (c & (a ^ b)).
  - The carry out of bit 7 is Cout.
- Arithmetic: {Cout, Sum} = A + B + Cin, a 9-bit unsigned result. Sum wraps modulo 256.
- Latency and update rule:
  - One cycle. On the rising clk edge where in_valid = 1, all outputs are loaded from the combinational chain and out_valid is set to 1.
  - On a rising edge where in_valid = 0, Sum, Cout, Overflow and Zero hold their previous values and out_valid is cleared to 0.
- Throughput: one operation per cycle. Back-to-back valid inputs produce back-to-back valid outputs with no stalls.
- Reset:
  - While rst = 1, and immediately when rst rises regardless of clk, Sum = 0, Cout = 0, Overflow = 0, Zero = 1 and out_valid = 0.
  - An operation presented in the cycle rst is asserted is discarded.
  - The first rising edge after rst falls samples inputs normally.
- No backpressure: out_valid is a 1-cycle pulse per accepted input, and the consumer must capture it in that cycle.
- Boundary cases:
  - 255 + 0 + 1 gives Sum = 0, Cout = 1, Zero = 1.
  - 255 + 255 + 1 gives Sum = 255, Cout = 1.
  - 127 + 1 + 0 gives Sum = 128, Overflow = 1, Cout = 0.
  - 128 + 128 + 0 gives Sum = 0, Cout = 1, Overflow = 1, Zero = 1.
- No X propagation from unused state: every register has a reset value.

Test Plan:
- Reset:
  - Assert rst mid-run with out_valid = 1 and without a clk edge.
  - Required response: outputs go immediately to Sum = 0, Cout = 0, Overflow = 0, Zero = 1, out_valid = 0.
- Basic sequence, with in_valid = 1 each cycle, one result per cycle, each one cycle after its inputs (as {Cout, Sum}):
  - 3+6+0 → 0, 9.
  - 12+8+1 → 0, 21.
  - 2+9+0 → 0, 11.
  - 5+7+1 → 0, 13.
  - 5+11+0 → 0, 16.
  - 1+12+1 → 0, 14.
  - 7+3+0 → 0, 10.
  - 8+6+1 → 0, 15.
- Carry and wrap:
  - 255+0+1 → Sum = 0, Cout = 1, Zero = 1.
  - 255+255+1 → Sum = 255, Cout = 1, Zero = 0.
  - 200+100+0 → Sum = 44, Cout = 1.
- Signed overflow:
  - 127+1+0 → Sum = 128, Overflow = 1, Cout = 0.
  - 128+128+0 → Sum = 0, Overflow = 1, Cout = 1.
  - 100+(-50, i.e. 206)+0 → Sum = 50, Overflow = 0, Cout = 1.
- Valid gating:
  - Present 10+20+0 with in_valid = 0 after a valid 3+6+0.
  - Required response: Sum stays 9 and out_valid drops to 0.
  - Then 10+20+0 with in_valid = 1 → Sum = 30 and out_valid = 1 next cycle.
- Exhaustive random check:
  - 10k random (A, B, Cin) with random in_valid.
  - Required response: every out_valid result matches the reference model {Cout, Sum} = A + B + Cin, and the flags are consistent with it.

Source files
------------

// File: rtl/rca8_registered.sv
// 8-bit ripple-carry adder with a registered result stage.
// Sum, carry-out and status flags appear one clock after qualified operands.
module rca8_registered #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             out_valid
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic             ovf_comb;
    logic             zero_comb;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic p;
        assign p            = A[i] ^ B[i];
        assign sum_comb[i]  = p ^ carry[i];
        assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & p);
    end

    // Signed overflow: carry into the sign bit disagrees with carry out of it
    assign ovf_comb  = carry[WIDTH] ^ carry[WIDTH - 1];
    assign zero_comb = (sum_comb == '0);

    // NOTE: state registers use non-blocking assignments so every output
    // updates from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum       <= '0;
            Cout      <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum      <= sum_comb;
                Cout     <= carry[WIDTH];
                Overflow <= ovf_comb;
                Zero     <= zero_comb;
            end
        end
    end

endmodule

// File: tb/tb_rca8_registered.sv
// Self-checking bench for rca8_registered: directed boundary cases plus
// random operands against an arithmetic reference model.
module tb_rca8_registered;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] A, B;
    logic       Cin;
    logic [7:0] Sum;
    logic       Cout, Overflow, Zero, out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the registered outputs should hold
    logic [7:0] m_sum;
    logic       m_cout, m_ovf, m_zero, m_valid;

    rca8_registered #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(A), .B(B), .Cin(Cin),
        .Sum(Sum), .Cout(Cout), .Overflow(Overflow), .Zero(Zero),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sum   = 8'd0;
        m_cout  = 1'b0;
        m_ovf   = 1'b0;
        m_zero  = 1'b1;
        m_valid = 1'b0;
    endtask

    // Plain integer arithmetic: unsigned 9-bit total and signed range test
    task automatic model_update(input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic v);
        int total, sa, sb, st;
        m_valid = v;
        if (v) begin
            total  = int'(a) + int'(b) + int'(cin);
            sa     = (a >= 8'd128) ? int'(a) - 256 : int'(a);
            sb     = (b >= 8'd128) ? int'(b) - 256 : int'(b);
            st     = sa + sb + int'(cin);
            m_sum  = 8'(total % 256);
            m_cout = (total > 255);
            m_zero = ((total % 256) == 0);
            m_ovf  = (st > 127) || (st < -128);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sum"},       32'(Sum),       32'(m_sum));
        check({tag, ".cout"},      32'(Cout),      32'(m_cout));
        check({tag, ".ovf"},       32'(Overflow),  32'(m_ovf));
        check({tag, ".zero"},      32'(Zero),      32'(m_zero));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    endtask

    // Drive on the falling edge, let the rising edge capture, sample 1 ns later
    task automatic step(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic v, input string tag);
        @(negedge clk);
        A = a; B = b; Cin = cin; in_valid = v;
        @(posedge clk);
        if (!rst) model_update(a, b, cin, v);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] exp;
    } vec_t;

    vec_t basic[8] = '{
        '{8'd3,  8'd6,  1'b0, 9'd9},  '{8'd12, 8'd8, 1'b1, 9'd21},
        '{8'd2,  8'd9,  1'b0, 9'd11}, '{8'd5,  8'd7, 1'b1, 9'd13},
        '{8'd5,  8'd11, 1'b0, 9'd16}, '{8'd1,  8'd12, 1'b1, 9'd14},
        '{8'd7,  8'd3,  1'b0, 9'd10}, '{8'd8,  8'd6, 1'b1, 9'd15}
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
        model_reset();
        #2;
        check_all("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back basic sequence, one result per cycle
        foreach (basic[i]) begin
            step(basic[i].a, basic[i].b, basic[i].cin, 1'b1, $sformatf("basic%0d", i));
            check($sformatf("basic%0d.const", i), 32'({Cout, Sum}), 32'(basic[i].exp));
        end

        // Carry and wrap
        step(8'd255, 8'd0, 1'b1, 1'b1, "wrap0");
        check("wrap0.const", 32'({Zero, Cout, Sum}), 32'({1'b1, 1'b1, 8'd0}));
        step(8'd255, 8'd255, 1'b1, 1'b1, "wrap255");
        check("wrap255.const", 32'({Zero, Cout, Sum}), 32'({1'b0, 1'b1, 8'd255}));
        step(8'd200, 8'd100, 1'b0, 1'b1, "wrap44");
        check("wrap44.const", 32'({Cout, Sum}), 32'({1'b1, 8'd44}));

        // Signed overflow
        step(8'd127, 8'd1, 1'b0, 1'b1, "ovf_pos");
        check("ovf_pos.const", 32'({Overflow, Cout, Sum}), 32'({1'b1, 1'b0, 8'd128}));
        step(8'd128, 8'd128, 1'b0, 1'b1, "ovf_neg");
        check("ovf_neg.const", 32'({Zero, Overflow, Cout, Sum}), 32'({1'b1, 1'b1, 1'b1, 8'd0}));
        step(8'd100, 8'd206, 1'b0, 1'b1, "no_ovf");
        check("no_ovf.const", 32'({Overflow, Cout, Sum}), 32'({1'b0, 1'b1, 8'd50}));

        // Valid gating
        step(8'd3, 8'd6, 1'b0, 1'b1, "gate_a");
        step(8'd10, 8'd20, 1'b0, 1'b0, "gate_hold");
        check("gate_hold.const", 32'({out_valid, Sum}), 32'({1'b0, 8'd9}));
        step(8'd10, 8'd20, 1'b0, 1'b1, "gate_b");
        check("gate_b.const", 32'({out_valid, Sum}), 32'({1'b1, 8'd30}));

        // Asynchronous reset between edges while out_valid is high
        step(8'd77, 8'd88, 1'b1, 1'b1, "pre_rst");
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        check("rst_async.const", 32'({out_valid, Zero, Overflow, Cout, Sum}),
              32'({1'b0, 1'b1, 1'b0, 1'b0, 8'd0}));
        step(8'd1, 8'd2, 1'b0, 1'b1, "rst_discard");
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        step(8'd40, 8'd2, 1'b0, 1'b1, "post_rst");

        // Random operands with random qualification
        for (int n = 0; n < 10000; n++) begin
            step(8'($urandom), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
